// File: rtl/audio_sdm_tx_if.sv
// Stereo sample handshake between the APU (master) and the audio serializer (slave).
// A pair transfers when sample_valid and sample_ready are both high at a rising edge.
interface audio_sdm_tx_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sample_l;
  logic [WIDTH-1:0] sample_r;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/audio_sdm_tx.sv
// Stereo first-order sigma-delta serializer: one pending pair buffer, two PDM
// modulators, time-multiplexed onto audiolr (right bit on even cycles, left on odd).
module audio_sdm_tx #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rstn,
  audio_sdm_tx_if.slave smp,
  input  logic          mute,
  input  logic          ovf_clr,
  output logic          ovf,
  output logic          audiolr
);

  logic       ph_reg;
  logic       pend_v_reg;
  logic       pend_v_next;
  logic       ovf_reg;
  logic       ovf_next;
  logic       audiolr_reg;
  logic       audiolr_next;
  logic       accept;
  logic       drop;
  logic       promote;
  logic [1:0] carry;

  assign accept           = smp.sample_valid && !pend_v_reg;
  assign drop             = smp.sample_valid && pend_v_reg;
  // Promote only after the right channel has stepped, so both channels switch on one frame.
  assign promote          = ph_reg && pend_v_reg;
  assign smp.sample_ready = !pend_v_reg;

  // Channel 0 is left (steps at ph=0), channel 1 is right (steps at ph=1).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      localparam logic STEP_PH = (gi == 1);

      logic [WIDTH-1:0] acc_reg;
      logic [WIDTH-1:0] cur_reg;
      logic [WIDTH-1:0] pend_reg;
      logic [WIDTH-1:0] smp_data;
      logic [WIDTH:0]   sum;

      assign smp_data  = (gi == 0) ? smp.sample_l : smp.sample_r;
      assign sum       = {1'b0, acc_reg} + {1'b0, cur_reg};
      assign carry[gi] = sum[WIDTH];

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          acc_reg  <= '0;
          cur_reg  <= '0;
          pend_reg <= '0;
        end else begin
          if (mute) begin
            acc_reg <= '0;
          end else if (ph_reg == STEP_PH) begin
            acc_reg <= sum[WIDTH-1:0];
          end
          if (accept) begin
            pend_reg <= smp_data;
          end
          if (promote) begin
            cur_reg <= pend_reg;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    pend_v_next = pend_v_reg;
    if (promote) begin
      pend_v_next = 1'b0;
    end else if (accept) begin
      pend_v_next = 1'b1;
    end

    // A dropped offer wins over a same-cycle clear.
    ovf_next = ovf_reg;
    if (drop) begin
      ovf_next = 1'b1;
    end else if (ovf_clr) begin
      ovf_next = 1'b0;
    end

    audiolr_next = mute ? 1'b0 : carry[ph_reg];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph_reg      <= 1'b0;
      pend_v_reg  <= 1'b0;
      ovf_reg     <= 1'b0;
      audiolr_reg <= 1'b0;
    end else begin
      ph_reg      <= !ph_reg;
      pend_v_reg  <= pend_v_next;
      ovf_reg     <= ovf_next;
      audiolr_reg <= audiolr_next;
    end
  end

  assign ovf     = ovf_reg;
  assign audiolr = audiolr_reg;

endmodule

// File: doc/audio_sdm_tx.md
Name: audio_sdm_tx

Overview:
- Chip-side audio serializer that drives the single-pin `audiolr` output.
- Accepts unsigned stereo PCM sample pairs from the APU through a valid/ready handshake.
- Converts each channel to a 1-bit first-order sigma-delta (PDM) stream.
- Time-multiplexes the two streams on alternating clocks: right channel on even cycles after reset, left on odd cycles, matching the board-side L/R demultiplexer.

Parameters:
- WIDTH, 16, sample width in bits (unsigned, offset-binary). Output density = sample / 2^WIDTH.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- sample_l  in  WIDTH  left-channel sample.
- sample_r  in  WIDTH  right-channel sample.
- sample_valid  in  1  sample pair present on `sample_l`/`sample_r`.
- sample_ready  out  1  pending slot free; the pair is accepted when `sample_valid` and `sample_ready` are both high at a rising edge.
- mute  in  1  forces silence and clears modulator state.
- ovf_clr  in  1  clears the `ovf` flag.
- ovf  out  1  sticky flag: a pair was offered while `sample_ready` was low.
- audiolr  out  1  registered multiplexed PDM bit.

Behaviour:
- Reset (async, `rstn` low) clears everything:
  - phase `ph`=0; `audiolr`=0; `ovf`=0; `sample_ready`=1;
  - accumulators `acc_l`, `acc_r` = 0;
  - current samples `cur_l`, `cur_r` = 0; pending registers empty.
- Phase:
  - `ph` toggles every clock.
  - The cycle with `ph`=0 presents the right bit on `audiolr`; `ph`=1 presents the left bit.
  - The first cycle after reset release is `ph`=0 and carries `audiolr`=0 (right channel).
- Modulator step (WIDTH-bit accumulator; carry-out is the bit):
  - At an edge with `ph`=0: `{bit, acc_l}` = `acc_l` + `cur_l` (WIDTH+1-bit sum); `audiolr` <= bit. The left bit is visible during the `ph`=1 cycle.
  - At an edge with `ph`=1: same computation on `acc_r`/`cur_r`; `audiolr` <= bit, visible during the next `ph`=0 cycle.
  - Each channel steps once per 2 clocks; the accumulator wraps modulo 2^WIDTH.
- Input buffering: one pending pair register (`pend_l`, `pend_r`, `pend_v`).
  - `sample_ready` = !`pend_v` (registered state, no combinational path from `sample_valid`).
  - Accept: `pend_v`<=1 and the pair is captured.
- Promotion:
  - Occurs only at an edge with `ph`=1, after the right bit is computed from the old `cur_r`.
  - If `pend_v`=1, then `cur_l`/`cur_r` <= pending and `pend_v`<=0.
  - The new pair therefore first affects the left bit computed at the following `ph`=0 edge, so both channels always switch on the same frame.
- Simultaneous accept and promote at one edge (`pend_v`=1, `sample_valid`=1, `ph`=1):
  - `sample_ready` was 0, so the offer is dropped and `ovf` is set.
  - Promotion proceeds normally.
- If no pending pair exists, `cur_l`/`cur_r` hold indefinitely; there is no underrun.
- Overflow:
  - `sample_valid`=1 with `sample_ready`=0 sets `ovf`; the offered data is discarded.
  - `ovf_clr` clears `ovf`; set has priority if both occur at the same edge.
- Mute (synchronous, sampled every edge):
  - While high: `acc_l`=`acc_r`=0 and `audiolr` <= 0.
  - `ph` keeps toggling; the handshake, pending register and promotion continue normally.
  - On release, modulation restarts from zero accumulators on the next step.
- Boundary values:
  - sample=0 gives all-zero bits.
  - sample=2^WIDTH-1 gives exactly one 0 per 2^WIDTH steps, the first step being 0.
- Reset mid-operation: immediate return to reset values. Any pending pair is lost and `ph` restarts at 0.

Test Plan:
- Reset release with no input -> `audiolr`=0 on every cycle; `ph` alternates starting at 0; `sample_ready`=1; `ovf`=0.
- Offer pair L=0x8000, R=0x0000 at cycle 0 -> promotion at the first `ph`=1 edge. Left bits (odd cycles) thereafter are 0,1,0,1…; right bits (even cycles) stay 0.
- L=0x4000, R=0xC000 -> over 8 left steps the left stream is 0,0,0,1 repeated (2 ones); the right stream is 0,1,1,1 repeated (6 ones).
- Offer two pairs back-to-back while the slot is full -> the second offer is dropped; `ovf`=1 until `ovf_clr` is pulsed; the first pair takes effect on the left bit after the next `ph`=1 edge.
- L=R=0xFFFF with `mute` high for 10 cycles, then low -> `audiolr`=0 throughout mute. After release, the first step per channel is 0, then all 1s.
- Assert `rstn` low mid-stream with a pending pair -> all outputs are at reset values immediately (asynchronously). After release, `audiolr`=0 and `sample_ready`=1; the pending pair is never applied.
